mem_sram: RTL



---
 rtl/mem_sram.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_sram.sv
`default_nettype none
// ============================================================================
// Module   : mem_sram
// Purpose  : Byte-addressed synchronous SRAM slave with configurable wait
//            states. Serves little-endian 8/16-bit accesses for the memory
//            controller. Optional macro MEM_SRAM_SIZE_CHECK_EN adds O_error
//            and blocks reserved-size (2'b1x) accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_sram #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_exec,
  input  logic        I_write,
  input  logic [1:0]  I_size,
  input  logic [15:0] I_addr,
  input  logic [15:0] I_data,
  output logic        O_ready,
  output logic [15:0] O_data,
  output logic        O_data_ready
`ifdef MEM_SRAM_SIZE_CHECK_EN
  ,
  output logic        O_error
`endif
);

  localparam int         DEPTH   = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [1:0]             size_q, size_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [15:0]            rdata_q, rdata_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   err_d;

  // Storage array; deliberately outside the reset domain so contents survive reset.
  logic [7:0]             mem_q [DEPTH];

  logic [ADDR_BITS-1:0]   addr_p1;
  logic                   done;
  logic                   is_word;
  logic                   is_rsvd;
  logic [15:0]            rd_word;

  // Address bits above the decoded range alias onto the same bytes.
  logic                   unused_addr_hi;
  assign unused_addr_hi = ^I_addr[15:ADDR_BITS];

  // Second byte of a word access wraps around the top of the array.
  assign addr_p1 = addr_q + ADDR_BITS'(1);
  assign done    = (state_q == ST_BUSY) && (cnt_q == 4'd0);

`ifdef MEM_SRAM_SIZE_CHECK_EN
  assign is_rsvd = size_q[1];
  assign is_word = (size_q == 2'b01);
`else
  // Reserved sizes fall through to word behaviour.
  assign is_rsvd = 1'b0;
  assign is_word = (size_q != 2'b00);
`endif

  assign rd_word = is_rsvd ? 16'h0000 :
                   is_word ? {mem_q[addr_p1], mem_q[addr_q]} :
                             {8'h00, mem_q[addr_q]};

  // Control and datapath registers; async reset drops any in-flight request.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: capture in IDLE, count down in BUSY, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_exec) begin
          write_d = I_write;
          size_d  = I_size;
          addr_d  = I_addr[ADDR_BITS-1:0];
          wdata_d = I_data;
          cnt_d   = WAIT_LD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d = is_rsvd;
          if (write_q) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = rd_word;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write commit on the completion edge; reserved sizes never commit.
  always_ff @(posedge I_clk) begin
    if (done && write_q && !is_rsvd) begin
      mem_q[addr_q] <= wdata_q[7:0];
      if (is_word) begin
        mem_q[addr_p1] <= wdata_q[15:8];
      end
    end
  end

`ifdef MEM_SRAM_SIZE_CHECK_EN
  logic err_q;

  // Error flag lands in the cycle after completion: with RESP for reads, first IDLE cycle for writes.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign O_error = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
`endif

  assign O_ready      = (state_q == ST_IDLE);
  assign O_data       = rdata_q;
  assign O_data_ready = (state_q == ST_RESP);

endmodule
`default_nettype wire
